csa_resolve_pipe: RTL and testbench
===================================

// Module: csa_resolve_pipe
// PURPOSE
//  Converts a carry-save pair (sum vector, carry vector), as produced by generic_csa
//  trees, back to a plain binary word. The block is a segmented, pipelined
//  carry-propagate adder with a valid/ready handshake on both sides.
//  It sits at the output of multi-operand CSA reduction trees: accumulators,
//  multipliers and checksum units.
// PARAMETERS
//  DW    32  operand/result width; must satisfy DW % NSEG == 0
//  NSEG  4   pipeline segments, >= 1; SEGW = DW/NSEG bits are resolved per stage
// PORTS
//  clk        in   1   single clock; all state updates on the rising edge
//  rst_n      in   1   asynchronous, active-low reset
//  in_sum     in   DW  carry-save sum vector
//  in_carry   in   DW  carry-save carry vector, already left-aligned (weight 2^i at bit i)
//  in_valid   in   1   in_sum/in_carry are valid
//  in_ready   out  1   block accepts the pair this cycle (in_valid && in_ready)
//  out_data   out  DW  (in_sum + in_carry) mod 2^DW
//  out_cout   out  1   carry out of bit DW-1
//  out_valid  out  1   out_data/out_cout are valid
//  out_ready  in   1   downstream accepts the result
// BEHAVIOUR
//  - Reset (async assert, sync deassert handled upstream): all stage valids = 0,
//    out_valid = 0, out_data = 0, out_cout = 0. Datapath registers also clear to 0.
//  - Stage k (0..NSEG-1) registers the following:
//      - resolved bits [(k+1)*SEGW-1:0]
//      - the carry into segment k+1
//      - the unresolved upper operand bits, delayed unchanged
//    Stage k adds the segment-k slices plus the incoming carry. Stage 0 has carry-in 0.
//  - Latency with no stall: a pair accepted at edge t appears on out_* after edge
//    t+NSEG-1, i.e. out_valid is high in cycle t+NSEG. NSEG=1 gives one registered stage.
//  - Throughput: one result per cycle while out_ready=1.
//  - Stage ready rule: ready_k = !valid_k || ready_{k+1}, with ready_NSEG = out_ready
//    and in_ready = ready_0. Bubbles collapse: an empty stage accepts data while later
//    stages stall.
//  - in_ready has a combinational dependency on out_ready. There is no path from
//    in_valid to out_*.
//  - Stall: while out_valid && !out_ready, out_data/out_cout/out_valid hold stable.
//    No pair is dropped or duplicated.
//  - Full: with all NSEG stages valid and out_ready=0, in_ready=0.
//    Simultaneous accept and emit in the same cycle is legal and keeps occupancy.
//  - Arithmetic: the sum is modular, and out_cout is the true 2^DW carry. carry[0]
//    is used as given; the block does not assume carry[0]=0.
//  - in_valid=1 with in_ready=0: inputs are ignored; the source must hold them.
//  - Reset mid-operation: in-flight pairs are discarded, and out_valid drops
//    immediately (asynchronously).
//  - Ordering: results leave in the same order the pairs were accepted.
// STRUCTURE
//  - csa_pkg holds:
//      - function seg_lo(k, SEGW), the segment bit offset
//      - typedef csa_pair_t {sum, carry} parameterised via DW
//      - a compile-time check that DW % NSEG == 0
//  - Sub-module csa_seg_stage: one segment adder plus its valid/ready register slice.
//    It is instantiated NSEG times in a generate loop, and the top adds only the
//    handshake chaining.
// TESTING
//  1. Reset, then 0x0000_0005 + 0x0000_000A, NSEG=4, out_ready=1:
//     out_data=0x0000_000F, cout=0, out_valid exactly 4 cycles after accept.
//  2. Full-width carry ripple: 0xFFFF_FFFF + 0x0000_0001 -> out_data=0, cout=1.
//     Carry must cross all segment boundaries.
//  3. Back-to-back stream of 100 random pairs, out_ready=1: one result per cycle,
//     in order, matching a reference model of (sum+carry) mod 2^32.
//  4. Backpressure: 6 pairs pushed with out_ready=0. in_ready drops after 4 accepts;
//     outputs are held stable. Then release with out_ready toggling 1/0: all 6 emerge
//     in order, no loss or duplication.
//  5. Bubble collapse: accept A, idle 2 cycles, accept B while out_ready=0.
//     B advances to stage NSEG-2 directly behind A.
//  6. Assert rst_n low mid-stream with 3 pairs in flight: out_valid=0 the same cycle.
//     After release no stale result appears, and the next pair 0x1234_0000+0x0000_5678
//     gives 0x1234_5678.
//  Repeat 1-3 with NSEG=1 and NSEG=32, DW=32.

Source files
------------

// File: rtl/csa_pkg.sv
// -----------------------------------------------------------------------------
// csa_pkg
//   Shared types and helpers for the carry-save resolve pipeline.
//   - CSA_DW / CSA_NSEG : default word width and segment count
//   - csa_pair_t        : a carry-save pair {sum, carry} at the default width
//   - seg_lo()          : bit offset of segment k for a given segment width
//   - csa_cfg_ok()      : legality of a (DW, NSEG) pairing, checked at elaboration
// -----------------------------------------------------------------------------
package csa_pkg;

  localparam int unsigned CSA_DW   = 32;
  localparam int unsigned CSA_NSEG = 4;

  typedef struct packed {
    logic [CSA_DW-1:0] sum;
    logic [CSA_DW-1:0] carry;
  } csa_pair_t;

  function automatic int unsigned seg_lo(input int unsigned k, input int unsigned segw);
    return k * segw;
  endfunction

  // Every segment must be the same width, so NSEG has to divide DW exactly.
  function automatic bit csa_cfg_ok(input int unsigned dw, input int unsigned nseg);
    return (nseg >= 1) && (dw >= nseg) && ((dw % nseg) == 0);
  endfunction

endpackage : csa_pkg

// File: rtl/csa_seg_stage.sv
// -----------------------------------------------------------------------------
// csa_seg_stage
//   One pipeline slice of the carry-propagate adder. It adds segment K of the
//   carry-save pair plus the incoming segment carry, merges the result into the
//   partially resolved word, and registers everything behind a valid/ready slice.
//
//   Upstream side  : valid_i, ready_o, sum_i, carry_i, res_i, cin_i
//   Downstream side: valid_o, ready_i, sum_o, carry_o, res_o, cout_o
//   res_*  : bits [(K+1)*SEGW-1:0] resolved after this stage, upper bits zero
//   cout_o : carry into segment K+1 (for the last stage, carry out of the word)
// -----------------------------------------------------------------------------
module csa_seg_stage
  import csa_pkg::*;
#(
  parameter int unsigned DW   = 32,
  parameter int unsigned SEGW = 8,
  parameter int unsigned K    = 0
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          valid_i,
  output logic          ready_o,
  input  logic [DW-1:0] sum_i,
  input  logic [DW-1:0] carry_i,
  input  logic [DW-1:0] res_i,
  input  logic          cin_i,
  output logic          valid_o,
  input  logic          ready_i,
  output logic [DW-1:0] sum_o,
  output logic [DW-1:0] carry_o,
  output logic [DW-1:0] res_o,
  output logic          cout_o
);

  localparam int unsigned LO = seg_lo(K, SEGW);

  logic [SEGW:0]  seg_add;
  logic [DW-1:0]  res_d;
  logic           cout_d;

  logic           valid_q;
  logic [DW-1:0]  sum_q;
  logic [DW-1:0]  carry_q;
  logic [DW-1:0]  res_q;
  logic           cout_q;

  // NOTE: every variable gets a default before any conditional or partial
  // assignment in always_comb, so no path can leave it unassigned (no latch).
  always_comb begin
    seg_add = {1'b0, sum_i[LO +: SEGW]} + {1'b0, carry_i[LO +: SEGW]}
            + {{SEGW{1'b0}}, cin_i};
    res_d   = res_i;
    res_d[LO +: SEGW] = seg_add[SEGW-1:0];
    cout_d  = seg_add[SEGW];
  end

  // The slice can take new data when it is empty or its content leaves this
  // cycle; this is what lets bubbles collapse behind a stalled stage.
  assign ready_o = !valid_q || ready_i;

  // NOTE: sequential state uses non-blocking assignments only, so every
  // register samples pre-edge values regardless of process ordering.
  // NOTE: datapath registers are reset too, so out_data reads zero after
  // reset instead of stale operands.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      valid_q <= 1'b0;
      sum_q   <= '0;
      carry_q <= '0;
      res_q   <= '0;
      cout_q  <= 1'b0;
    end else if (ready_o) begin
      valid_q <= valid_i;
      // Data only moves with a real transfer, keeping outputs quiet otherwise.
      if (valid_i) begin
        sum_q   <= sum_i;
        carry_q <= carry_i;
        res_q   <= res_d;
        cout_q  <= cout_d;
      end
    end
  end

  // Operands travel as whole words so every stage has the same port shape;
  // bits already resolved are simply never read downstream.
  assign valid_o = valid_q;
  assign sum_o   = sum_q;
  assign carry_o = carry_q;
  assign res_o   = res_q;
  assign cout_o  = cout_q;

endmodule : csa_seg_stage

// File: rtl/csa_resolve_pipe.sv
// -----------------------------------------------------------------------------
// csa_resolve_pipe
//   Resolves a carry-save pair (in_sum, in_carry) into a binary word with an
//   NSEG-deep segmented carry-propagate pipeline. Each stage resolves DW/NSEG
//   bits; stages are chained with a per-stage valid/ready handshake.
//
//   in_sum, in_carry : carry-save operands (in_carry already weighted 2^i at bit i)
//   in_valid/in_ready: upstream handshake; in_ready depends on out_ready
//   out_data         : (in_sum + in_carry) mod 2^DW
//   out_cout         : carry out of bit DW-1
//   out_valid/out_ready: downstream handshake
// -----------------------------------------------------------------------------
module csa_resolve_pipe
  import csa_pkg::*;
#(
  parameter int unsigned DW   = CSA_DW,
  parameter int unsigned NSEG = CSA_NSEG
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic [DW-1:0] in_sum,
  input  logic [DW-1:0] in_carry,
  input  logic          in_valid,
  output logic          in_ready,
  output logic [DW-1:0] out_data,
  output logic          out_cout,
  output logic          out_valid,
  input  logic          out_ready
);

  if (!csa_cfg_ok(DW, NSEG)) begin : g_bad_cfg
    $error("csa_resolve_pipe: DW must be a non-zero multiple of NSEG");
  end

  localparam int unsigned SEGW = DW / NSEG;

  // Index k is the input side of stage k; index NSEG is the pipe output.
  logic          valid_c [NSEG+1];
  logic          ready_c [NSEG+1];
  logic [DW-1:0] sum_c   [NSEG+1];
  logic [DW-1:0] carry_c [NSEG+1];
  logic [DW-1:0] res_c   [NSEG+1];
  logic          cin_c   [NSEG+1];

  assign valid_c[0] = in_valid;
  assign sum_c[0]   = in_sum;
  assign carry_c[0] = in_carry;
  assign res_c[0]   = '0;
  assign cin_c[0]   = 1'b0;
  assign in_ready   = ready_c[0];

  assign ready_c[NSEG] = out_ready;
  assign out_valid     = valid_c[NSEG];
  assign out_data      = res_c[NSEG];
  assign out_cout      = cin_c[NSEG];

  for (genvar k = 0; k < NSEG; k++) begin : g_stage
    csa_seg_stage #(
      .DW   (DW),
      .SEGW (SEGW),
      .K    (k)
    ) u_stage (
      .clk     (clk),
      .rst_n   (rst_n),
      .valid_i (valid_c[k]),
      .ready_o (ready_c[k]),
      .sum_i   (sum_c[k]),
      .carry_i (carry_c[k]),
      .res_i   (res_c[k]),
      .cin_i   (cin_c[k]),
      .valid_o (valid_c[k+1]),
      .ready_i (ready_c[k+1]),
      .sum_o   (sum_c[k+1]),
      .carry_o (carry_c[k+1]),
      .res_o   (res_c[k+1]),
      .cout_o  (cin_c[k+1])
    );
  end

endmodule : csa_resolve_pipe

// File: tb/tb_csa_resolve_pipe.sv
// -----------------------------------------------------------------------------
// tb_csa_resolve_pipe
//   Three instances (NSEG = 4, 1, 32; DW = 32) share one stimulus stream. A
//   per-instance expectation queue holds (sum + carry) as a 33-bit number for
//   every accepted pair; results are checked in order as they appear.
//   Directed sequences target latency, carry ripple, backpressure, bubble
//   collapse and mid-stream reset on the NSEG=4 instance.
// -----------------------------------------------------------------------------
module tb_csa_resolve_pipe;
  import csa_pkg::*;

  localparam int unsigned NDUT = 3;
  localparam csa_pair_t   IDLE = '0;

  logic        clk       = 1'b0;
  logic        rst_n     = 1'b0;
  logic [31:0] in_sum    = '0;
  logic [31:0] in_carry  = '0;
  logic        in_valid  = 1'b0;
  logic        out_ready = 1'b0;

  logic        in_ready_a  [NDUT];
  logic [31:0] out_data_a  [NDUT];
  logic        out_cout_a  [NDUT];
  logic        out_valid_a [NDUT];

  int unsigned n_vec = 0;
  int unsigned n_err = 0;

  logic [32:0] exp_q [NDUT][$];

  always #5 clk = ~clk;

  csa_resolve_pipe #(.DW(32), .NSEG(4)) u_dut_s4 (
    .clk(clk), .rst_n(rst_n), .in_sum(in_sum), .in_carry(in_carry),
    .in_valid(in_valid), .in_ready(in_ready_a[0]), .out_data(out_data_a[0]),
    .out_cout(out_cout_a[0]), .out_valid(out_valid_a[0]), .out_ready(out_ready));

  csa_resolve_pipe #(.DW(32), .NSEG(1)) u_dut_s1 (
    .clk(clk), .rst_n(rst_n), .in_sum(in_sum), .in_carry(in_carry),
    .in_valid(in_valid), .in_ready(in_ready_a[1]), .out_data(out_data_a[1]),
    .out_cout(out_cout_a[1]), .out_valid(out_valid_a[1]), .out_ready(out_ready));

  csa_resolve_pipe #(.DW(32), .NSEG(32)) u_dut_s32 (
    .clk(clk), .rst_n(rst_n), .in_sum(in_sum), .in_carry(in_carry),
    .in_valid(in_valid), .in_ready(in_ready_a[2]), .out_data(out_data_a[2]),
    .out_cout(out_cout_a[2]), .out_valid(out_valid_a[2]), .out_ready(out_ready));

  function automatic int unsigned nseg_of(input int unsigned d);
    case (d)
      0:       return 4;
      1:       return 1;
      default: return 32;
    endcase
  endfunction

  // Plain-integer reference: the full 33-bit sum of the two operands.
  function automatic logic [32:0] ref_sum(input csa_pair_t p);
    return 33'(p.sum) + 33'(p.carry);
  endfunction

  function automatic csa_pair_t rand_pair();
    csa_pair_t p;
    p.sum = $urandom;
    case ($urandom_range(0, 3))
      0:       p.carry = ~p.sum;            // all ones, no carry out
      1:       p.carry = (~p.sum) + 32'd1;  // long ripple to a carry out
      default: p.carry = $urandom;
    endcase
    return p;
  endfunction

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
    end
  endtask

  // Scoreboard: handshakes are evaluated mid-cycle, where inputs are stable,
  // and describe the transfer that happens at the next rising edge.
  always @(negedge rst_n) begin
    for (int d = 0; d < NDUT; d++) exp_q[d].delete();
  end

  for (genvar d = 0; d < NDUT; d++) begin : g_mon
    always @(negedge clk) begin
      if (rst_n) begin
        if (out_valid_a[d]) begin
          if (exp_q[d].size() == 0) begin
            check($sformatf("spurious_out[%0d]", d), 64'(out_valid_a[d]), 64'd0);
          end else begin
            check($sformatf("result[%0d]", d),
                  {31'd0, out_cout_a[d], out_data_a[d]}, 64'(exp_q[d][0]));
            if (out_ready) void'(exp_q[d].pop_front());
          end
        end
        if (in_valid && in_ready_a[d]) begin
          csa_pair_t p;
          p.sum   = in_sum;
          p.carry = in_carry;
          exp_q[d].push_back(ref_sum(p));
        end
      end
    end
  end

  // One cycle of stimulus: present inputs just after an edge, note whether the
  // NSEG=4 instance accepts, then step to just after the next edge.
  task automatic drive(input bit v, input csa_pair_t p, input bit ordy, output bit acc);
    in_valid  = v;
    in_sum    = p.sum;
    in_carry  = p.carry;
    out_ready = ordy;
    #1;
    acc = v && in_ready_a[0];
    @(posedge clk);
    #1;
  endtask

  function automatic bit all_empty();
    for (int d = 0; d < NDUT; d++) if (exp_q[d].size() != 0) return 1'b0;
    return 1'b1;
  endfunction

  task automatic drain(input string tag);
    bit acc;
    for (int i = 0; i < 40 && !all_empty(); i++) drive(1'b0, IDLE, 1'b1, acc);
    for (int d = 0; d < NDUT; d++)
      check($sformatf("%s_left[%0d]", tag, d), 64'(exp_q[d].size()), 64'd0);
  endtask

  initial begin
    bit        acc;
    int        idx;
    csa_pair_t p;
    csa_pair_t bp [6];

    // Reset state
    repeat (2) @(posedge clk);
    #1;
    for (int d = 0; d < NDUT; d++) begin
      check($sformatf("rst_valid[%0d]", d), 64'(out_valid_a[d]), 64'd0);
      check($sformatf("rst_data[%0d]", d),  64'(out_data_a[d]),  64'd0);
      check($sformatf("rst_cout[%0d]", d),  64'(out_cout_a[d]),  64'd0);
    end
    rst_n = 1'b1;
    @(posedge clk);
    #1;

    // 1: single pair, exact latency per instance
    p.sum = 32'h0000_0005; p.carry = 32'h0000_000A;
    drive(1'b1, p, 1'b1, acc);
    check("t1_accept", 64'(acc), 64'd1);
    for (int j = 0; j < 34; j++) begin
      for (int d = 0; d < NDUT; d++)
        check($sformatf("t1_valid[%0d][%0d]", d, j), 64'(out_valid_a[d]),
              64'(j == int'(nseg_of(d)) - 1));
      if (j == 3) check("t1_data", 64'(out_data_a[0]), 64'h0000_000F);
      drive(1'b0, IDLE, 1'b1, acc);
    end
    drain("t1");

    // 2: carry ripple across every segment, and carry[0] used as given
    p.sum = 32'hFFFF_FFFF; p.carry = 32'h0000_0001;
    drive(1'b1, p, 1'b1, acc);
    check("t2a_accept", 64'(acc), 64'd1);
    p.sum = 32'h8000_0000; p.carry = 32'h8000_0001;
    drive(1'b1, p, 1'b1, acc);
    check("t2b_accept", 64'(acc), 64'd1);
    drain("t2");

    // 3: back-to-back random stream at full rate
    for (int i = 0; i < 100; i++) begin
      drive(1'b1, rand_pair(), 1'b1, acc);
      check($sformatf("t3_accept[%0d]", i), 64'(acc), 64'd1);
    end
    drain("t3");

    // 4: backpressure, fill to capacity, then drain with toggling out_ready
    for (int i = 0; i < 6; i++) bp[i] = rand_pair();
    idx = 0;
    for (int i = 0; i < 4; i++) begin
      drive(1'b1, bp[idx], 1'b0, acc);
      if (acc) idx++;
    end
    check("t4_accepts", 64'(idx), 64'd4);
    for (int i = 0; i < 3; i++) begin
      drive(1'b1, bp[idx], 1'b0, acc);
      check($sformatf("t4_full[%0d]", i), 64'(acc), 64'd0);
      check($sformatf("t4_hold_valid[%0d]", i), 64'(out_valid_a[0]), 64'd1);
    end
    for (int c = 0; c < 60 && (idx < 6 || exp_q[0].size() != 0); c++) begin
      drive(idx < 6, (idx < 6) ? bp[idx] : IDLE, (c % 2) == 0, acc);
      if (acc) idx++;
    end
    check("t4_all_in", 64'(idx), 64'd6);
    check("t4_all_out", 64'(exp_q[0].size()), 64'd0);
    drain("t4");

    // 5: bubble collapse behind a stalled head
    drive(1'b1, rand_pair(), 1'b0, acc);
    check("t5_a", 64'(acc), 64'd1);
    drive(1'b0, IDLE, 1'b0, acc);
    drive(1'b0, IDLE, 1'b0, acc);
    drive(1'b1, rand_pair(), 1'b0, acc);
    check("t5_b", 64'(acc), 64'd1);
    drive(1'b0, IDLE, 1'b0, acc);
    drive(1'b1, rand_pair(), 1'b0, acc);
    check("t5_c", 64'(acc), 64'd1);
    drive(1'b1, rand_pair(), 1'b0, acc);
    check("t5_d", 64'(acc), 64'd1);
    drive(1'b1, rand_pair(), 1'b0, acc);
    check("t5_full", 64'(acc), 64'd0);
    for (int i = 0; i < 4; i++) begin
      check($sformatf("t5_stream[%0d]", i), 64'(out_valid_a[0]), 64'd1);
      drive(1'b0, IDLE, 1'b1, acc);
    end
    drain("t5");

    // 6: reset with pairs in flight
    for (int i = 0; i < 3; i++) drive(1'b1, rand_pair(), 1'b1, acc);
    in_valid = 1'b0;
    rst_n    = 1'b0;
    #1;
    for (int d = 0; d < NDUT; d++)
      check($sformatf("t6_valid_drop[%0d]", d), 64'(out_valid_a[d]), 64'd0);
    @(posedge clk);
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    for (int i = 0; i < 5; i++) begin
      drive(1'b0, IDLE, 1'b1, acc);
      for (int d = 0; d < NDUT; d++)
        check($sformatf("t6_no_stale[%0d][%0d]", d, i), 64'(out_valid_a[d]), 64'd0);
    end
    p.sum = 32'h1234_0000; p.carry = 32'h0000_5678;
    drive(1'b1, p, 1'b1, acc);
    check("t6_accept", 64'(acc), 64'd1);
    for (int i = 0; i < 10 && !out_valid_a[0]; i++) drive(1'b0, IDLE, 1'b1, acc);
    check("t6_valid", 64'(out_valid_a[0]), 64'd1);
    check("t6_data", 64'(out_data_a[0]), 64'h1234_5678);
    drain("t6");

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule : tb_csa_resolve_pipe
